// File: rtl/pipelined_adder.sv
`default_nettype none
// =============================================================================
// Module   : pipelined_adder
// Summary  : Segmented adder. Each stage adds one SEGMENT-bit slice. Stages
//            pass valid/ready flow control with a single global advance.
//            The optional macro PIPELINED_ADDER_OVERFLOW_EN adds the signed
//            Overflow output.
// Revision : 1.0 - initial release
// =============================================================================
module pipelined_adder #(
  parameter int WIDTH   = 32,
  parameter int SEGMENT = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIN,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOUT,
  output logic             OutValid,
  input  logic             OutReady
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int STAGES = WIDTH / SEGMENT;

  logic             r_vld [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             w_adv;

  // One advance signal moves the whole pipe, so a full pipe drains at line rate.
  assign w_adv    = OutReady | ~r_vld[STAGES-1];
  assign InReady  = w_adv;
  assign OutValid = r_vld[STAGES-1];
  assign Sum      = r_s[STAGES-1];
  assign CarryOUT = r_c[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s_in;
    logic [WIDTH-1:0] w_s_nxt;
    logic             w_c_in;
    logic             w_v_in;
    logic [SEGMENT:0] w_seg;

    if (k == 0) begin : g_first
      assign w_a    = A;
      assign w_b    = B;
      assign w_s_in = '0;
      assign w_c_in = CarryIN;
      assign w_v_in = InValid;
    end else begin : g_next
      assign w_a    = r_a[k-1];
      assign w_b    = r_b[k-1];
      assign w_s_in = r_s[k-1];
      assign w_c_in = r_c[k-1];
      assign w_v_in = r_vld[k-1];
    end

    assign w_seg = {1'b0, w_a[k*SEGMENT +: SEGMENT]}
                 + {1'b0, w_b[k*SEGMENT +: SEGMENT]}
                 + {{SEGMENT{1'b0}}, w_c_in};

    always_comb begin
      w_s_nxt = w_s_in;
      w_s_nxt[k*SEGMENT +: SEGMENT] = w_seg[SEGMENT-1:0];
    end

    always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        r_vld[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end else if (w_adv) begin
        r_vld[k] <= w_v_in;
        r_c[k]   <= w_seg[SEGMENT];
        r_a[k]   <= w_a;
        r_b[k]   <= w_b;
        r_s[k]   <= w_s_nxt;
      end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      logic r_ovf;
      // Like-signed operands producing an opposite-signed sum: this matches
      // carry-into-MSB XOR carry-out-of-MSB.
      always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_s_nxt[WIDTH-1] != w_a[WIDTH-1]);
        end
      end
      assign Overflow = r_ovf;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// =============================================================================
// Module   : tb_pipelined_adder
// Summary  : Directed bench for pipelined_adder (WIDTH=32, SEGMENT=8).
// Revision : 1.0 - initial release
// =============================================================================
module tb_pipelined_adder;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [31:0] A, B, Sum;
  logic        CarryIN, InValid, InReady, CarryOUT, OutValid, OutReady;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic        Overflow;
`endif

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.WIDTH(32), .SEGMENT(8)) dut (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .A       (A),
    .B       (B),
    .CarryIN (CarryIN),
    .InValid (InValid),
    .InReady (InReady),
    .Sum     (Sum),
    .CarryOUT(CarryOUT),
    .OutValid(OutValid),
    .OutReady(OutReady)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    .Overflow(Overflow)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry, sum}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] s;
    logic        ov;
    s  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov = (a[31] == b[31]) && (s[31] != a[31]);
    return {ov, s};
  endfunction

  task automatic one_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] es, input logic eco, input logic eov);
    int lat;
    A = a; B = b; CarryIN = ci; InValid = 1'b1; OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(Sum), 64'(es));
    chk({tag, "_cout"}, 64'(CarryOUT), 64'(eco));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    chk({tag, "_ovf"}, 64'(Overflow), 64'(eov));
`else
    if (eov === 1'bx) chk({tag, "_ovf_arg"}, 64'(eov), 64'd0);
`endif
    tick();
    chk({tag, "_single"}, 64'(OutValid), 64'd0);
  endtask

  logic [33:0] q[$];
  logic [33:0] e;
  logic [32:0] held;
  logic        did_in, did_out;
  int          nsent, nrecv, cyc;

  initial begin
    ResetN = 1'b0; A = '0; B = '0; CarryIN = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    #3;
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_sum", 64'(Sum), 64'd0);
    chk("rst_cout", 64'(CarryOUT), 64'd0);
    tick(); tick();
    ResetN = 1'b1;
    tick();
    chk("rel_inready", 64'(InReady), 64'd1);

    one_beat("ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    one_beat("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    one_beat("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one_beat("mixed", 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 32'h2222_2221, 1'b0, 1'b0);

    // Ten back-to-back sets, downstream stalls during cycles 5..9
    nsent = 0; nrecv = 0; cyc = 0; held = '0;
    while ((nsent < 10 || nrecv < 10) && cyc < 60) begin
      OutReady = !(cyc >= 5 && cyc <= 9);
      InValid  = (nsent < 10);
      A        = 32'h0123_4567 * (nsent + 1);
      B        = 32'hFEDC_BA98 ^ (nsent << 5);
      CarryIN  = nsent[0];
      #1;
      if (cyc >= 5 && cyc <= 9) begin
        chk("hold_inready", 64'(InReady), 64'd0);
        chk("hold_outvalid", 64'(OutValid), 64'd1);
        if (cyc == 5) held = {CarryOUT, Sum};
        else chk("hold_stable", 64'({CarryOUT, Sum}), 64'(held));
      end
      did_out = OutValid && OutReady;
      did_in  = InValid && InReady;
      if (did_out) begin
        if (q.size() == 0) chk("b2b_spurious", 64'(OutValid), 64'd0);
        else begin
          e = q.pop_front();
          chk("b2b_result", 64'({CarryOUT, Sum}), 64'(e[32:0]));
          nrecv++;
        end
      end
      if (did_in) begin
        q.push_back(model(A, B, CarryIN));
        nsent++;
      end
      tick();
      cyc++;
    end
    chk("b2b_count", 64'(nrecv), 64'd10);
    InValid = 1'b0; OutReady = 1'b1;
    q.delete();
    tick();

    // Reset with one result at the output and three more in flight
    for (int i = 0; i < 4; i++) begin
      A = 32'hAAAA_0000 + i; B = 32'h0000_5555; CarryIN = 1'b1; InValid = 1'b1;
      tick();
    end
    InValid = 1'b0;
    chk("mid_pre_outvalid", 64'(OutValid), 64'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("mid_outvalid", 64'(OutValid), 64'd0);
    chk("mid_sum", 64'(Sum), 64'd0);
    chk("mid_cout", 64'(CarryOUT), 64'd0);
    tick();
    ResetN = 1'b1;
    #1;
    chk("mid_rel_inready", 64'(InReady), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_ghost", 64'(OutValid), 64'd0);
    end

    // Randomised traffic against the reference model
    nsent = 0; nrecv = 0; cyc = 0;
    while ((nsent < 10000 || nrecv < nsent) && cyc < 40000) begin
      OutReady = ($urandom_range(3) != 0);
      InValid  = (nsent < 10000) && ($urandom_range(3) != 0);
      A        = $urandom;
      B        = $urandom;
      CarryIN  = $urandom_range(1);
      #1;
      did_out = OutValid && OutReady;
      did_in  = InValid && InReady;
      if (did_out) begin
        if (q.size() == 0) chk("rnd_spurious", 64'(OutValid), 64'd0);
        else begin
          e = q.pop_front();
          chk("rnd_result", 64'({CarryOUT, Sum}), 64'(e[32:0]));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
          chk("rnd_ovf", 64'(Overflow), 64'(e[33]));
`endif
          nrecv++;
        end
      end
      if (did_in) begin
        q.push_back(model(A, B, CarryIN));
        nsent++;
      end
      tick();
      cyc++;
    end
    chk("rnd_count", 64'(nrecv), 64'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
